// File: rtl/xbus_arbiter.sv
// Round-robin CPU/DMA arbiter for the shared memory bus cycle: one owner at a time,
// a dead cycle between owners, and a watchdog that forces release of a stuck cycle.
module xbus_arbiter #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic CLK,
   input  logic RESET,
   input  logic REQ_CPU,
   input  logic REQ_DMA,
   input  logic DONE,
   input  logic ERR_CLR,
   output logic GNT_CPU,
   output logic GNT_DMA,
   output logic BUSY,
   output logic TIMEOUT_ERR,
   output logic ERR,
   output logic ERR_OWNER
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_DEAD  = 2'd2
   } state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;
   localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

   state_t           state_q, state_d;
   logic             owner_q, owner_d;
   logic             ptr_q, ptr_d;
   logic [CNT_W-1:0] wdog_q, wdog_d;
   logic             gnt_cpu_q, gnt_cpu_d;
   logic             gnt_dma_q, gnt_dma_d;
   logic             busy_q, busy_d;
   logic             tmo_q, tmo_d;
   logic             err_q, err_d;
   logic             err_owner_q, err_owner_d;

   logic any_req;
   logic winner;
   logic owner_req;
   logic expired;

   assign any_req   = REQ_CPU | REQ_DMA;
   // Contention is settled by the pointer; a sole requester simply wins.
   assign winner    = (REQ_CPU & REQ_DMA) ? ptr_q : REQ_DMA;
   assign owner_req = (owner_q == OWN_DMA) ? REQ_DMA : REQ_CPU;
   // DONE on the last allowed beat is a normal completion, not a timeout.
   assign expired   = (wdog_q == WD_LAST) && !DONE;

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      ptr_d       = ptr_q;
      wdog_d      = '0;
      tmo_d       = 1'b0;
      err_owner_d = err_owner_q;
      err_d       = ERR_CLR ? 1'b0 : err_q;

      unique case (state_q)
         S_IDLE, S_DEAD: begin
            if (any_req) begin
               state_d = S_GRANT;
               owner_d = winner;
               ptr_d   = ~winner;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_GRANT: begin
            if (DONE || !owner_req || expired) begin
               state_d = S_DEAD;
               if (expired) begin
                  tmo_d       = 1'b1;
                  err_d       = 1'b1;
                  err_owner_d = owner_q;
               end
            end else begin
               wdog_d = (wdog_q == WD_LAST) ? wdog_q : wdog_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      gnt_cpu_d = (state_d == S_GRANT) && (owner_d == OWN_CPU);
      gnt_dma_d = (state_d == S_GRANT) && (owner_d == OWN_DMA);
      busy_d    = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         owner_q     <= OWN_CPU;
         ptr_q       <= OWN_CPU;
         wdog_q      <= '0;
         gnt_cpu_q   <= 1'b0;
         gnt_dma_q   <= 1'b0;
         busy_q      <= 1'b0;
         tmo_q       <= 1'b0;
         err_q       <= 1'b0;
         err_owner_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         ptr_q       <= ptr_d;
         wdog_q      <= wdog_d;
         gnt_cpu_q   <= gnt_cpu_d;
         gnt_dma_q   <= gnt_dma_d;
         busy_q      <= busy_d;
         tmo_q       <= tmo_d;
         err_q       <= err_d;
         err_owner_q <= err_owner_d;
      end
   end

   assign GNT_CPU     = gnt_cpu_q;
   assign GNT_DMA     = gnt_dma_q;
   assign BUSY        = busy_q;
   assign TIMEOUT_ERR = tmo_q;
   assign ERR         = err_q;
   assign ERR_OWNER   = err_owner_q;

endmodule

// File: tb/tb_xbus_arbiter.sv
// Self-checking bench for xbus_arbiter: directed scenarios with literal expectations,
// then random traffic compared every cycle against a cycle-count based reference model.
module tb_xbus_arbiter;

   localparam int T = 4;

   logic clk = 1'b0;
   logic reset, req_cpu, req_dma, done, err_clr;
   logic gnt_cpu, gnt_dma, busy, timeout_err, err, err_owner;

   int checks = 0;
   int errors = 0;
   bit check_en = 1'b0;

   // Reference model: who owns the bus, how many grant cycles it has had, and who is preferred next.
   int m_owner     = -1;
   bit m_dead      = 1'b0;
   int m_held      = 0;
   int m_pref      = 0;
   bit m_err       = 1'b0;
   bit m_err_owner = 1'b0;
   bit m_tmo       = 1'b0;

   xbus_arbiter #(.TIMEOUT(T), .CNT_W(3)) dut (
      .CLK        (clk),
      .RESET      (reset),
      .REQ_CPU    (req_cpu),
      .REQ_DMA    (req_dma),
      .DONE       (done),
      .ERR_CLR    (err_clr),
      .GNT_CPU    (gnt_cpu),
      .GNT_DMA    (gnt_dma),
      .BUSY       (busy),
      .TIMEOUT_ERR(timeout_err),
      .ERR        (err),
      .ERR_OWNER  (err_owner)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input logic r, input logic rc, input logic rd, input logic d, input logic ec);
      reset   = r;
      req_cpu = rc;
      req_dma = rd;
      done    = d;
      err_clr = ec;
      @(negedge clk);
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_owner     = -1;
         m_dead      = 1'b0;
         m_held      = 0;
         m_pref      = 0;
         m_err       = 1'b0;
         m_err_owner = 1'b0;
         m_tmo       = 1'b0;
      end else begin
         m_tmo = 1'b0;
         if (err_clr) m_err = 1'b0;
         if (m_owner >= 0) begin
            m_held++;
            if (done) begin
               m_owner = -1;
               m_dead  = 1'b1;
            end else if (m_held >= T) begin
               m_tmo       = 1'b1;
               m_err       = 1'b1;
               m_err_owner = (m_owner == 1);
               m_owner     = -1;
               m_dead      = 1'b1;
            end else if (!((m_owner == 0) ? req_cpu : req_dma)) begin
               m_owner = -1;
               m_dead  = 1'b1;
            end
         end else begin
            m_dead = 1'b0;
            if (req_cpu || req_dma) begin
               m_owner = (req_cpu && req_dma) ? m_pref : (req_dma ? 1 : 0);
               m_pref  = 1 - m_owner;
               m_held  = 0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (check_en) begin
         check("model_gnt_cpu",     gnt_cpu,     m_owner == 0);
         check("model_gnt_dma",     gnt_dma,     m_owner == 1);
         check("model_busy",        busy,        (m_owner >= 0) || m_dead);
         check("model_timeout_err", timeout_err, m_tmo);
         check("model_err",         err,         m_err);
         check("model_err_owner",   err_owner,   m_err_owner);
         check("gnt_exclusive",     gnt_cpu & gnt_dma, 1'b0);
      end
   end

   initial begin
      reset = 1'b1; req_cpu = 1'b0; req_dma = 1'b0; done = 1'b0; err_clr = 1'b0;

      // Reset held three cycles with both requesting.
      tick(1, 1, 1, 0, 0);
      check_en = 1'b1;
      tick(1, 1, 1, 0, 0);
      tick(1, 1, 1, 0, 0);
      check("rst_gnt_cpu", gnt_cpu, 1'b0);
      check("rst_gnt_dma", gnt_dma, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_tmo", timeout_err, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_err_owner", err_owner, 1'b0);
      tick(0, 1, 1, 0, 0);
      check("rst_first_gnt_cpu", gnt_cpu, 1'b1);
      check("rst_first_busy", busy, 1'b1);

      // Alternation with DONE on the second grant cycle.
      for (int k = 0; k < 4; k++) begin
         check("alt_gnt_cpu", gnt_cpu, (k % 2) == 0);
         check("alt_gnt_dma", gnt_dma, (k % 2) == 1);
         tick(0, 1, 1, 0, 0);
         check("alt_hold", gnt_cpu | gnt_dma, 1'b1);
         tick(0, 1, 1, 1, 0);
         check("alt_dead_gnt", gnt_cpu | gnt_dma, 1'b0);
         check("alt_dead_busy", busy, 1'b1);
         if (k < 3) tick(0, 1, 1, 0, 0);
      end
      tick(0, 0, 0, 0, 0);
      check("idle_busy", busy, 1'b0);

      // Timeout: DMA alone, no DONE.
      tick(0, 0, 1, 0, 0);
      check("tmo_gnt_c1", gnt_dma, 1'b1);
      for (int i = 0; i < 3; i++) begin
         tick(0, 0, 1, 0, 0);
         check("tmo_gnt_held", gnt_dma, 1'b1);
         check("tmo_no_early_pulse", timeout_err, 1'b0);
      end
      tick(0, 0, 1, 0, 0);
      check("tmo_gnt_drop", gnt_dma, 1'b0);
      check("tmo_pulse", timeout_err, 1'b1);
      check("tmo_err", err, 1'b1);
      check("tmo_err_owner", err_owner, 1'b1);
      tick(0, 0, 0, 0, 0);
      check("tmo_pulse_end", timeout_err, 1'b0);
      check("tmo_err_sticky", err, 1'b1);
      tick(0, 0, 0, 0, 1);
      check("errclr_err", err, 1'b0);
      check("errclr_owner_kept", err_owner, 1'b1);

      // Abort: CPU drops request on its third cycle, DMA follows after one dead cycle.
      tick(0, 1, 1, 0, 0);
      check("abort_gnt_cpu", gnt_cpu, 1'b1);
      tick(0, 1, 1, 0, 0);
      tick(0, 0, 1, 0, 0);
      check("abort_drop", gnt_cpu, 1'b0);
      check("abort_dead", gnt_dma, 1'b0);
      check("abort_no_tmo", timeout_err, 1'b0);
      tick(0, 0, 1, 0, 0);
      check("abort_next_dma", gnt_dma, 1'b1);

      // DONE on the watchdog's last cycle.
      for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, 0);
      check("coll_done_held", gnt_dma, 1'b1);
      tick(0, 0, 1, 1, 0);
      check("coll_done_drop", gnt_dma, 1'b0);
      check("coll_done_no_tmo", timeout_err, 1'b0);
      check("coll_done_no_err", err, 1'b0);

      // ERR_CLR coincident with a timeout.
      tick(0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) tick(0, 0, 1, 0, 0);
      tick(0, 0, 1, 0, 1);
      check("coll_clr_tmo", timeout_err, 1'b1);
      check("coll_clr_err", err, 1'b1);

      // DONE while idle.
      tick(0, 0, 0, 0, 0);
      tick(0, 0, 0, 1, 0);
      check("idle_done_busy", busy, 1'b0);
      check("idle_done_gnt", gnt_cpu | gnt_dma, 1'b0);
      check("idle_done_err", err, 1'b1);

      // Reset mid-grant, then pointer back to CPU.
      tick(0, 0, 1, 0, 0);
      check("mrst_gnt_dma", gnt_dma, 1'b1);
      tick(1, 0, 1, 0, 0);
      check("mrst_drop", gnt_dma, 1'b0);
      check("mrst_no_tmo", timeout_err, 1'b0);
      check("mrst_err", err, 1'b0);
      tick(0, 1, 0, 0, 0);
      check("mrst_cpu_grant", gnt_cpu, 1'b1);
      tick(1, 1, 1, 0, 0);
      check("mrst2_drop", gnt_cpu, 1'b0);
      tick(0, 1, 1, 0, 0);
      check("mrst2_ptr_cpu", gnt_cpu, 1'b1);
      check("mrst2_ptr_dma", gnt_dma, 1'b0);

      // Back-to-back same requester with DONE every cycle.
      for (int i = 0; i < 4; i++) begin
         tick(0, 1, 0, 1, 0);
         check("b2b_pattern", gnt_cpu, (i % 2) == 1);
      end

      // Random traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         tick($urandom_range(0, 63) == 0,
              $urandom_range(0, 9) < 7,
              $urandom_range(0, 9) < 7,
              $urandom_range(0, 3) == 0,
              $urandom_range(0, 9) == 0);
      end

      tick(0, 0, 0, 0, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
